// File: rtl/cond_flag_unit.sv
// ARM condition evaluation against the architectural NZCV register, with write gating,
// a one-entry valid/ready output stage and a saturating squash counter.
module cond_flag_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_w,
    input  logic [3:0]       alu_flags,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] squash_count
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic accept;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // Flags only move on accepts, so an output held under stall never changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            pc_src       <= 1'b0;
            reg_write    <= 1'b0;
            mem_write    <= 1'b0;
            cond_ex      <= 1'b0;
            flags        <= '0;
            squash_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            pc_src    <= pcs & cond_pass;
            reg_write <= reg_w & ~no_write & cond_pass;
            mem_write <= mem_w & cond_pass;
            cond_ex   <= cond_pass;
            if (cond_pass) begin
                if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
            end else if (squash_count != '1) begin
                squash_count <= squash_count + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed and randomized checks of cond_flag_unit against an ARM-style reference model.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] cond = '0;
    logic [1:0] flag_w = '0;
    logic [3:0] alu_flags = '0;
    logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
    logic [7:0] squash_count;
    logic       in_ready2, out_valid2, pc_src2, reg_write2, mem_write2, cond_ex2;
    logic [3:0] flags2;
    logic [1:0] squash_count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_w(flag_w), .alu_flags(alu_flags), .pcs(pcs),
        .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write), .out_valid(out_valid),
        .out_ready(out_ready), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .cond_ex(cond_ex), .flags(flags),
        .squash_count(squash_count)
    );

    cond_flag_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .cond(cond), .flag_w(flag_w), .alu_flags(alu_flags), .pcs(pcs),
        .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write), .out_valid(out_valid2),
        .out_ready(out_ready), .pc_src(pc_src2), .reg_write(reg_write2),
        .mem_write(mem_write2), .cond_ex(cond_ex2), .flags(flags2),
        .squash_count(squash_count2)
    );

    // ARM style: even codes give the base test, odd codes its inverse; 111x is always.
    function automatic bit arm_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    bit         m_ov, m_pc, m_rw, m_mw, m_cx;
    logic [3:0] m_flags;
    int         m_cnt, m_cnt2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ov <= 0; m_pc <= 0; m_rw <= 0; m_mw <= 0; m_cx <= 0;
            m_flags <= '0; m_cnt <= 0; m_cnt2 <= 0;
        end else if (in_valid && (!m_ov || out_ready)) begin
            bit p;
            logic [3:0] nf;
            p = arm_cond(cond, m_flags);
            m_ov <= 1;
            m_pc <= pcs && p;
            m_rw <= reg_w && !no_write && p;
            m_mw <= mem_w && p;
            m_cx <= p;
            nf = m_flags;
            if (p && flag_w[1]) nf[3:2] = alu_flags[3:2];
            if (p && flag_w[0]) nf[1:0] = alu_flags[1:0];
            m_flags <= nf;
            if (!p) begin
                m_cnt  <= (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 <= (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
        end else if (out_ready) begin
            m_ov <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = !m_ov || out_ready;
        check("in_ready", int'(in_ready), int'(exp_ready));
        check("out_valid", int'(out_valid), int'(m_ov));
        check("pc_src", int'(pc_src), int'(m_pc));
        check("reg_write", int'(reg_write), int'(m_rw));
        check("mem_write", int'(mem_write), int'(m_mw));
        check("cond_ex", int'(cond_ex), int'(m_cx));
        check("flags", int'(flags), int'(m_flags));
        check("squash_count", int'(squash_count), m_cnt);
        check("out_valid2", int'(out_valid2), int'(m_ov));
        check("flags2", int'(flags2), int'(m_flags));
        check("cond_ex2", int'(cond_ex2), int'(m_cx));
        check("squash_count2", int'(squash_count2), m_cnt2);
    end

    task automatic cycle(input bit v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input bit p, input bit rw, input bit mw,
                         input bit nw, input bit ordy);
        in_valid = v; cond = c; flag_w = fw; alu_flags = af;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_count", int'(squash_count), 0);
        @(negedge clk);
        reset = 1'b0;

        cycle(1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 1);
        check("al_valid", int'(out_valid), 1);
        check("al_cond_ex", int'(cond_ex), 1);
        check("al_flags", int'(flags), 4'b0100);
        cycle(1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 1);
        check("eq_reg_write", int'(reg_write), 1);
        cycle(1, 4'b0001, 2'b11, 4'b1000, 0, 1, 0, 0, 1);
        check("ne_reg_write", int'(reg_write), 0);
        check("ne_cond_ex", int'(cond_ex), 0);
        check("ne_count", int'(squash_count), 1);
        check("ne_flags_kept", int'(flags), 4'b0100);

        cycle(1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0, 1);
        cycle(1, 4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        check("ge_fail", int'(cond_ex), 0);
        cycle(1, 4'b1011, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        check("lt_pass", int'(cond_ex), 1);
        cycle(1, 4'b1110, 2'b11, 4'b1001, 0, 0, 0, 0, 1);
        cycle(1, 4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        check("ge_pass", int'(cond_ex), 1);
        cycle(1, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        check("gt_pass", int'(cond_ex), 1);
        cycle(1, 4'b1110, 2'b10, 4'b0100, 0, 0, 0, 0, 1);
        check("setz_flags", int'(flags), 4'b0101);
        cycle(1, 4'b1101, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        check("le_pass", int'(cond_ex), 1);
        check("count_two", int'(squash_count), 2);

        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 0);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_mem_write", int'(mem_write), 0);
            check("stall_flags", int'(flags), 4'b0101);
        end
        cycle(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 1);
        check("release_valid", int'(out_valid), 1);
        check("release_mem_write", int'(mem_write), 1);
        check("release_flags", int'(flags), 4'b1111);

        cycle(1, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 1);
        cycle(1, 4'b1110, 2'b10, 4'b1111, 0, 0, 0, 0, 1);
        check("partial_nz", int'(flags), 4'b1100);
        cycle(1, 4'b1110, 2'b01, 4'b1111, 0, 0, 0, 0, 1);
        check("partial_cv", int'(flags), 4'b1111);

        for (int i = 0; i < 5; i++) cycle(1, 4'b0001, 2'b11, 4'b0000, 0, 1, 0, 0, 1);
        check("sat_count2", int'(squash_count2), 3);
        check("count_seven", int'(squash_count), 7);
        check("sat_flags", int'(flags), 4'b1111);

        #2;
        reset = 1'b1;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_flags", int'(flags), 0);
        check("async_count", int'(squash_count), 0);
        check("async_count2", int'(squash_count2), 0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] c, af;
            logic [1:0] fw;
            c  = 4'($urandom_range(0, 15));
            af = 4'($urandom_range(0, 15));
            fw = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), c, fw, af, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b1;
                #5;
                reset = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Stage directly downstream of the ALU and its flag generators (negative, zero, carry, overflow).
- Holds the architectural NZCV flags register and evaluates each instruction's ARM condition field against it.
- Gates the instruction's register, memory and PC writes, and conditionally updates NZCV from the ALU flags.
- Delivers the gated controls to the writeback side through a one-entry registered valid/ready stage, and keeps a saturating count of squashed (condition-failed) instructions.

Parameters:
- CNT_W, 8, width of squash_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction/ALU result valid.
- in_ready  out  1  stage can accept this cycle.
- cond  in  4  ARM condition field, Instr[31:28].
- flag_w  in  2  [1] = update N,Z; [0] = update C,V.
- alu_flags  in  4  {N,Z,C,V} from the ALU flag logic for this instruction.
- pcs  in  1  instruction writes PC.
- reg_w  in  1  instruction writes register file.
- mem_w  in  1  instruction writes memory.
- no_write  in  1  compare-type instruction: suppress reg_w.
- out_valid  out  1  gated result valid.
- out_ready  in  1  downstream accepts.
- pc_src  out  1  pcs & cond_ex.
- reg_write  out  1  reg_w & ~no_write & cond_ex.
- mem_write  out  1  mem_w & cond_ex.
- cond_ex  out  1  registered condition result.
- flags  out  4  architectural {N,Z,C,V}.
- squash_count  out  CNT_W  count of accepted instructions with a failed condition.

Behaviour:
- Reset: asynchronous and active-high. While asserted, all of the following are 0: out_valid, pc_src, reg_write, mem_write, cond_ex, flags, squash_count.
  - Asserting reset mid-stall drops the held output immediately; no write is ever delivered for it.
- Handshake: in_ready = ~out_valid | out_ready (combinational).
  - Accept occurs when in_valid & in_ready.
  - Latency: 1 cycle, from the accept edge to out_valid=1.
  - On an accept, the output register loads pc_src, reg_write, mem_write and cond_ex, and out_valid becomes 1.
  - With no accept: if out_ready & out_valid, out_valid goes to 0; otherwise the outputs hold bit-stable.
  - Accept in the same cycle as an output transfer: the new result replaces the old, and out_valid stays 1 (full throughput).
- Condition evaluation is combinational on cond and the current flags register, taken before any update made at the same edge:
  - 0000 EQ: Z.
  - 0001 NE: ~Z.
  - 0010 CS: C.
  - 0011 CC: ~C.
  - 0100 MI: N.
  - 0101 PL: ~N.
  - 0110 VS: V.
  - 0111 VC: ~V.
  - 1000 HI: C&~Z.
  - 1001 LS: ~C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 1 (treated as unconditional).
- Flag update happens only at an accept edge with cond_ex=1.
  - If flag_w[1]=1, N,Z load from alu_flags[3:2].
  - If flag_w[0]=1, C,V load from alu_flags[1:0].
  - The two halves update independently. Failed-condition instructions never modify flags.
- Back-to-back dependency: instruction i+1 is evaluated against the flags written by instruction i, because the update lands at i's accept edge. No bypass or bubble is required.
- Stall: flags change only on accepts, so a held output cannot be corrupted.
- squash_count increments by 1 on each accept with cond_ex=0 and saturates at 2^CNT_W-1 (no wrap).
- in_valid=0 cycles have no effect on flags or the counter.

Test Plan:
- Reset, then accept cond=1110, flag_w=11, alu_flags=0100 → next cycle out_valid=1 and cond_ex=1; flags=0100.
- With flags=0100, back-to-back instructions:
  - EQ reg_w=1 → reg_write=1.
  - Then NE reg_w=1 → reg_write=0, cond_ex=0, squash_count=1.
  - The NE instruction has flag_w=11, alu_flags=1000 → flags remain 0100.
- Signed compares: flags=1000 (N=1, V=0) → GE fails, LT passes. Then set flags=1001 → GE passes, GT passes. Then set Z=1 → LE passes.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs and flags stable. Then out_ready=1 → transfer plus new accept in the same cycle; out_valid stays 1.
- Partial update: flags=0000, accept AL flag_w=10, alu_flags=1111 → flags=1100. Then flag_w=01 → flags=1111.
- Saturation and reset:
  - CNT_W=2, 5 failed-condition accepts → squash_count=3.
  - Assert reset asynchronously mid-cycle while out_valid=1 → out_valid, flags and squash_count drop to 0 before the next edge.
